// File: rtl/write_once_sram_pkg.sv
// Shared types and helpers for the write-once SRAM.
// Optional build macro: WRITE_ONCE_SRAM_PARITY_EN (per-byte even parity).
package write_once_sram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_e;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/write_once_sram_if.sv
// Request/response and scrub-control bundle for write_once_sram.
// Signal suffixes are from the memory's point of view.
interface write_once_sram_if
    import write_once_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024
);
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam int BE_WIDTH   = be_width(DATA_WIDTH);

    logic                  req_i;
    logic                  gnt_o;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [BE_WIDTH-1:0]   be_i;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;
    logic                  scrub_req_i;
    logic                  busy_o;
    logic [ADDR_WIDTH:0]   locked_cnt_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, scrub_req_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, busy_o, locked_cnt_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, scrub_req_i,
        output gnt_o, rvalid_o, rdata_o, err_o, busy_o, locked_cnt_o
    );

endinterface

// File: rtl/write_once_lock_table.sv
// Lock bitmap with test/set port, per-index clear port and a saturating count
// of locked words. Bitmap and count clear asynchronously on rst_i.
module write_once_lock_table #(
    parameter int NUM_WORDS  = 1024,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] ts_idx_i,
    output logic                  ts_locked_o,
    input  logic                  ts_set_i,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_idx_i,
    input  logic                  cnt_clr_i,
    output logic [ADDR_WIDTH:0]   locked_cnt_o
);

    localparam logic [ADDR_WIDTH:0] NUM_WORDS_C = NUM_WORDS[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] CNT_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [NUM_WORDS-1:0] lock_q;
    logic [ADDR_WIDTH:0]  cnt_q;
    logic                 ts_in_range;

    assign ts_in_range  = ({1'b0, ts_idx_i} < NUM_WORDS_C);
    assign ts_locked_o  = ts_in_range && lock_q[ts_idx_i];
    assign locked_cnt_o = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= '0;
        end else begin
            if (ts_set_i) lock_q[ts_idx_i] <= 1'b1;
            if (clr_en_i) lock_q[clr_idx_i] <= 1'b0;
        end
    end

    // Set and clear never coincide: sets only happen while idle, clears only while scrubbing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (ts_set_i && (cnt_q != NUM_WORDS_C)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

endmodule

// File: rtl/write_once_sram.sv
// Write-once SRAM: each word locks on its first effective write; scrub zeroes all.
// Define WRITE_ONCE_SRAM_PARITY_EN to store and check one even-parity bit per byte.
module write_once_sram
    import write_once_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    write_once_sram_if.slave    bus
);

    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam int BE_WIDTH   = be_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   NUM_WORDS_C = NUM_WORDS[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE     = ADDR_WIDTH'(1);

    typedef struct packed {
        logic                  rvalid;
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } resp_t;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] scrub_idx_q;
    logic                  busy_q;
    resp_t                 resp_d;
    resp_t                 resp_q;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    logic                  accept;
    logic                  in_range;
    logic                  locked;
    logic                  wr_ok;
    logic                  scrub_we;
    logic                  scrub_last;
    logic                  par_err;
    logic [DATA_WIDTH-1:0] rd_word;

    assign bus.gnt_o    = (state_q == IDLE) && !bus.scrub_req_i;
    assign accept       = bus.req_i && bus.gnt_o;
    assign in_range     = ({1'b0, bus.addr_i} < NUM_WORDS_C);
    assign wr_ok        = accept && bus.we_i && in_range && !locked && (bus.be_i != '0);
    assign scrub_we     = (state_q == SCRUB);
    assign scrub_last   = scrub_we && (scrub_idx_q == LAST_IDX);
    assign rd_word      = mem_q[bus.addr_i];

    write_once_lock_table #(
        .NUM_WORDS  (NUM_WORDS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lock (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ts_idx_i     (bus.addr_i),
        .ts_locked_o  (locked),
        .ts_set_i     (wr_ok),
        .clr_en_i     (scrub_we),
        .clr_idx_i    (scrub_idx_q),
        .cnt_clr_i    (scrub_last),
        .locked_cnt_o (bus.locked_cnt_o)
    );

    // Array has no reset; a scrub is the only way to bring it to a known state.
    always_ff @(posedge clk_i) begin
        if (scrub_we) begin
            mem_q[scrub_idx_q] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (bus.be_i[b]) mem_q[bus.addr_i][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
            end
        end
    end

`ifdef WRITE_ONCE_SRAM_PARITY_EN
    logic [BE_WIDTH-1:0] par_q [NUM_WORDS];

    function automatic logic [BE_WIDTH-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [BE_WIDTH-1:0] p;
        p = '0;
        for (int b = 0; b < BE_WIDTH; b++) p[b] = ^d[b*8 +: 8];
        return p;
    endfunction

    always_ff @(posedge clk_i) begin
        if (scrub_we) begin
            par_q[scrub_idx_q] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (bus.be_i[b]) par_q[bus.addr_i][b] <= ^bus.wdata_i[b*8 +: 8];
            end
        end
    end

    assign par_err = (par_q[bus.addr_i] != byte_parity(rd_word));
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        resp_d = '0;
        if (accept) begin
            resp_d.rvalid = 1'b1;
            if (!in_range) begin
                resp_d.err = 1'b1;
            end else if (bus.we_i) begin
                resp_d.err = locked;
            end else begin
                resp_d.rdata = rd_word;
                resp_d.err   = par_err;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            scrub_idx_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.scrub_req_i) begin
                        state_q     <= SCRUB;
                        scrub_idx_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                SCRUB: begin
                    if (scrub_idx_q == LAST_IDX) begin
                        state_q     <= IDLE;
                        scrub_idx_q <= '0;
                        busy_q      <= 1'b0;
                    end else begin
                        scrub_idx_q <= scrub_idx_q + IDX_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rvalid_o = resp_q.rvalid;
    assign bus.err_o    = resp_q.err;
    assign bus.rdata_o  = resp_q.rdata;
    assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_write_once_sram.sv
// Directed bench for write_once_sram (DATA_WIDTH=32, NUM_WORDS=12) with a
// behavioural reference model compared every cycle.
module tb_write_once_sram;

    localparam int NW = 12;
    localparam int DW = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    write_once_sram_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus_if ();

    write_once_sram #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] kmask(input logic [3:0] k);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (k[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Reference model: word contents, known-byte mask, lock flags, lock count,
    // and the number of scrub cycles still to run.
    logic [31:0] m_mem  [NW];
    logic [3:0]  m_kn   [NW];
    logic        m_lock [NW];
    logic [31:0] m_flip [NW];
    int          m_cnt;
    int          scrub_left;
    int          a;
    logic        exp_rvalid, exp_err;
    logic [31:0] exp_rdata, exp_rmask;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exp_rvalid <= 1'b0;
            exp_err    <= 1'b0;
            exp_rdata  <= '0;
            exp_rmask  <= '1;
            m_cnt      <= 0;
            scrub_left <= 0;
            for (int i = 0; i < NW; i++) begin
                m_lock[i] <= 1'b0;
                m_kn[i]   <= 4'h0;
            end
        end else begin
            exp_rvalid <= 1'b0;
            exp_err    <= 1'b0;
            exp_rdata  <= '0;
            exp_rmask  <= '1;
            if (scrub_left != 0) begin
                m_mem[NW - scrub_left]  <= '0;
                m_kn[NW - scrub_left]   <= 4'hF;
                m_lock[NW - scrub_left] <= 1'b0;
                scrub_left <= scrub_left - 1;
                if (scrub_left == 1) m_cnt <= 0;
            end else if (bus_if.scrub_req_i) begin
                scrub_left <= NW;
            end else if (bus_if.req_i) begin
                exp_rvalid <= 1'b1;
                a = int'(bus_if.addr_i);
                if (a >= NW) begin
                    exp_err <= 1'b1;
                end else if (bus_if.we_i) begin
                    if (m_lock[a]) begin
                        exp_err <= 1'b1;
                    end else if (bus_if.be_i != 4'h0) begin
                        for (int b = 0; b < 4; b++) begin
                            if (bus_if.be_i[b]) begin
                                m_mem[a][b*8 +: 8] <= bus_if.wdata_i[b*8 +: 8];
                                m_kn[a][b]         <= 1'b1;
                            end
                        end
                        m_lock[a] <= 1'b1;
                        m_cnt     <= (m_cnt < NW) ? m_cnt + 1 : NW;
                    end
                end else begin
                    exp_rdata <= m_mem[a] ^ m_flip[a];
                    exp_rmask <= kmask(m_kn[a]);
                    exp_err   <= (m_flip[a] != 0);
                end
            end
        end
    end

    always @(negedge clk_i) begin
        chk("busy", 32'(bus_if.busy_o), 32'(scrub_left != 0));
        chk("locked_cnt", 32'(bus_if.locked_cnt_o), 32'(m_cnt));
        chk("gnt", 32'(bus_if.gnt_o), 32'((scrub_left == 0) && !bus_if.scrub_req_i));
        chk("rvalid", 32'(bus_if.rvalid_o), 32'(exp_rvalid));
        if (exp_rvalid) begin
            chk("err", 32'(bus_if.err_o), 32'(exp_err));
            chk("rdata", bus_if.rdata_o & exp_rmask, exp_rdata & exp_rmask);
        end
    end

    task automatic op(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                      input logic [3:0] be);
        bus_if.req_i   = 1'b1;
        bus_if.we_i    = we;
        bus_if.addr_i  = addr;
        bus_if.wdata_i = wd;
        bus_if.be_i    = be;
        @(posedge clk_i); #1;
        bus_if.req_i   = 1'b0;
        bus_if.we_i    = 1'b0;
        bus_if.be_i    = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int n_busy;

    initial begin
        for (int i = 0; i < NW; i++) m_flip[i] = '0;
        bus_if.req_i       = 1'b0;
        bus_if.we_i        = 1'b0;
        bus_if.addr_i      = '0;
        bus_if.wdata_i     = '0;
        bus_if.be_i        = '0;
        bus_if.scrub_req_i = 1'b0;
        #1 rst_i = 1'b1;

        @(negedge clk_i);
        chk("rst_rvalid", 32'(bus_if.rvalid_o), 32'd0);
        chk("rst_err", 32'(bus_if.err_o), 32'd0);
        chk("rst_busy", 32'(bus_if.busy_o), 32'd0);
        chk("rst_cnt", 32'(bus_if.locked_cnt_o), 32'd0);
        chk("rst_rdata", bus_if.rdata_o, 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // 1: first write locks, read returns data
        op(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        @(negedge clk_i);
        chk("t1_wr_rvalid", 32'(bus_if.rvalid_o), 32'd1);
        chk("t1_wr_err", 32'(bus_if.err_o), 32'd0);
        chk("t1_cnt", 32'(bus_if.locked_cnt_o), 32'd1);
        chk("t1_model_cnt", 32'(m_cnt), 32'd1);
        @(posedge clk_i); #1;
        op(1'b0, 4'd3, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("t1_rdata", bus_if.rdata_o, 32'hDEADBEEF);
        chk("t1_model_rdata", exp_rdata, 32'hDEADBEEF);
        @(posedge clk_i); #1;

        // 2: second write rejected
        op(1'b1, 4'd3, 32'h12345678, 4'hF);
        @(negedge clk_i);
        chk("t2_err", 32'(bus_if.err_o), 32'd1);
        chk("t2_rdata_zero", bus_if.rdata_o, 32'd0);
        @(posedge clk_i); #1;
        op(1'b0, 4'd3, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("t2_rdata", bus_if.rdata_o, 32'hDEADBEEF);
        chk("t2_cnt", 32'(bus_if.locked_cnt_o), 32'd1);
        @(posedge clk_i); #1;

        // 3: partial write locks; be=0 write does not
        op(1'b1, 4'd5, 32'h000000AA, 4'b0001);
        op(1'b0, 4'd5, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("t3_byte0", 32'(bus_if.rdata_o[7:0]), 32'hAA);
        @(posedge clk_i); #1;
        op(1'b1, 4'd5, 32'h0000BB00, 4'b0010);
        @(negedge clk_i);
        chk("t3_locked_err", 32'(bus_if.err_o), 32'd1);
        @(posedge clk_i); #1;
        op(1'b1, 4'd6, 32'h11111111, 4'h0);
        @(negedge clk_i);
        chk("t3_be0_err", 32'(bus_if.err_o), 32'd0);
        chk("t3_be0_cnt", 32'(bus_if.locked_cnt_o), 32'd2);
        @(posedge clk_i); #1;
        op(1'b1, 4'd6, 32'h66666666, 4'hF);
        @(negedge clk_i);
        chk("t3_addr6_unlocked", 32'(bus_if.err_o), 32'd0);
        @(posedge clk_i); #1;
        // back-to-back writes to one word
        op(1'b1, 4'd7, 32'hA5A5A5A5, 4'hF);
        op(1'b1, 4'd7, 32'h5A5A5A5A, 4'hF);
        @(negedge clk_i);
        chk("t3_b2b_err", 32'(bus_if.err_o), 32'd1);
        chk("t3_b2b_cnt", 32'(bus_if.locked_cnt_o), 32'd4);
        @(posedge clk_i); #1;

        // 4: out-of-range addresses
        op(1'b0, 4'd12, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("t4_rd_err", 32'(bus_if.err_o), 32'd1);
        @(posedge clk_i); #1;
        op(1'b1, 4'd12, 32'hFFFFFFFF, 4'hF);
        op(1'b1, 4'd15, 32'hFFFFFFFF, 4'hF);
        @(negedge clk_i);
        chk("t4_wr_err", 32'(bus_if.err_o), 32'd1);
        chk("t4_cnt", 32'(bus_if.locked_cnt_o), 32'd4);
        @(posedge clk_i); #1;

        // 5: scrub beats a same-cycle request; response in flight still returns
        op(1'b0, 4'd3, 32'h0, 4'h0);
        bus_if.scrub_req_i = 1'b1;
        bus_if.req_i       = 1'b1;
        bus_if.we_i        = 1'b1;
        bus_if.addr_i      = 4'd8;
        bus_if.wdata_i     = 32'h88888888;
        bus_if.be_i        = 4'hF;
        #1 chk("t5_gnt", 32'(bus_if.gnt_o), 32'd0);
        @(posedge clk_i); #1;
        bus_if.scrub_req_i = 1'b0;
        bus_if.req_i       = 1'b0;
        bus_if.we_i        = 1'b0;
        bus_if.be_i        = 4'h0;
        n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (bus_if.busy_o) n_busy++;
            else if (n_busy > 0) break;
        end
        chk("t5_busy_cycles", 32'(n_busy), 32'd12);
        chk("t5_cnt", 32'(bus_if.locked_cnt_o), 32'd0);
        @(posedge clk_i); #1;
        for (int i = 0; i < NW; i++) op(1'b0, 4'(i), 32'h0, 4'h0);
        @(negedge clk_i);
        chk("t5_rdata_zero", bus_if.rdata_o, 32'd0);
        @(posedge clk_i); #1;
        op(1'b1, 4'd3, 32'h33333333, 4'hF);
        @(negedge clk_i);
        chk("t5_rewrite_err", 32'(bus_if.err_o), 32'd0);
        chk("t5_rewrite_cnt", 32'(bus_if.locked_cnt_o), 32'd1);
        @(posedge clk_i); #1;

        // 6: reset during scrub cycle 4
        op(1'b1, 4'd10, 32'h10101010, 4'hF);
        bus_if.scrub_req_i = 1'b1;
        @(posedge clk_i); #1;
        bus_if.scrub_req_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        chk("t6_busy", 32'(bus_if.busy_o), 32'd0);
        chk("t6_cnt", 32'(bus_if.locked_cnt_o), 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        op(1'b1, 4'd10, 32'hCAFEF00D, 4'hF);
        @(negedge clk_i);
        chk("t6_rewrite_err", 32'(bus_if.err_o), 32'd0);
        chk("t6_rewrite_cnt", 32'(bus_if.locked_cnt_o), 32'd1);
        @(posedge clk_i); #1;
        op(1'b0, 4'd10, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("t6_rdata", bus_if.rdata_o, 32'hCAFEF00D);
        @(posedge clk_i); #1;

        // lock every word: count reaches NUM_WORDS and holds
        for (int i = 0; i < NW; i++) op(1'b1, 4'(i), 32'h01020300 + i, 4'hF);
        op(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF);
        @(negedge clk_i);
        chk("full_cnt", 32'(bus_if.locked_cnt_o), 32'd12);
        chk("full_err", 32'(bus_if.err_o), 32'd1);
        @(posedge clk_i); #1;

`ifdef WRITE_ONCE_SRAM_PARITY_EN
        m_flip[11] = 32'h1;
        dut.mem_q[11] = dut.mem_q[11] ^ 32'h1;
        op(1'b0, 4'd11, 32'h0, 4'h0);
        @(negedge clk_i);
        chk("par_err", 32'(bus_if.err_o), 32'd1);
        @(posedge clk_i); #1;
`endif

        repeat (2) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
